// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clear/feed/drain/done sequencer with diagonal operand skew for an MxK output-stationary array.
// Optional busy-cycle counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
    parameter int M = 5,
    parameter int N = 3,
    parameter int K = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PE_LAT = 1,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    x_rd_en,
    output logic [AW-1:0]           x_rd_addr,
    input  logic [DATA_WIDTH*M-1:0] x_rd_data,
    output logic                    w_rd_en,
    output logic [AW-1:0]           w_rd_addr,
    input  logic [DATA_WIDTH*K-1:0] w_rd_data,
    output logic [DATA_WIDTH*M-1:0] arr_x,
    output logic [DATA_WIDTH*K-1:0] arr_w,
    output logic                    arr_clr,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             perf_cycles
);
    localparam int D = M + K - 1 + PE_LAT;
    localparam int CN = (N > D) ? N : D;
    localparam int CW = (CN > 1) ? $clog2(CN) : 1;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_clr, r_rd, r_vld, r_busy, r_done;
    logic [DATA_WIDTH*M-1:0] w_x;
    logic [DATA_WIDTH*K-1:0] w_w;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_clr   <= 1'b0;
            r_rd    <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_clr  <= 1'b0;
            r_done <= 1'b0;
            r_vld  <= r_rd;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_CLEAR;
                    r_clr   <= 1'b1;
                    r_busy  <= 1'b1;
                end
                S_CLEAR: begin
                    r_state <= S_FEED;
                    r_rd    <= 1'b1;
                end
                S_FEED: if (r_cnt == CW'(N - 1)) begin
                    r_state <= S_DRAIN;
                    r_rd    <= 1'b0;
                    r_cnt   <= '0;
                end else r_cnt <= r_cnt + 1'b1;
                S_DRAIN: if (r_cnt == CW'(D - 1)) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                end else r_cnt <= r_cnt + 1'b1;
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign x_rd_en   = r_rd;
    assign w_rd_en   = r_rd;
    assign x_rd_addr = r_cnt[AW-1:0];
    assign w_rd_addr = r_cnt[AW-1:0];
    assign arr_clr   = r_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    // Unread slots inject zeros so fill/drain never disturbs the accumulators
    assign w_x = r_vld ? x_rd_data : '0;
    assign w_w = r_vld ? w_rd_data : '0;
    for (genvar i = 0; i < M; i++) begin : g_x
        if (i == 0) begin : g_0
            assign arr_x[DATA_WIDTH-1:0] = w_x[DATA_WIDTH-1:0];
        end else begin : g_d
            logic [DATA_WIDTH-1:0] r_sh [i];
            always_ff @(posedge clk) begin
                r_sh[0] <= rst ? '0 : w_x[DATA_WIDTH*i +: DATA_WIDTH];
                for (int s = 1; s < i; s++) r_sh[s] <= rst ? '0 : r_sh[s-1];
            end
            assign arr_x[DATA_WIDTH*i +: DATA_WIDTH] = r_sh[i-1];
        end
    end
    for (genvar j = 0; j < K; j++) begin : g_w
        if (j == 0) begin : g_0
            assign arr_w[DATA_WIDTH-1:0] = w_w[DATA_WIDTH-1:0];
        end else begin : g_d
            logic [DATA_WIDTH-1:0] r_sh [j];
            always_ff @(posedge clk) begin
                r_sh[0] <= rst ? '0 : w_w[DATA_WIDTH*j +: DATA_WIDTH];
                for (int s = 1; s < j; s++) r_sh[s] <= rst ? '0 : r_sh[s-1];
            end
            assign arr_w[DATA_WIDTH*j +: DATA_WIDTH] = r_sh[j-1];
        end
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk) begin
        r_perf <= rst ? '0 : (r_busy && r_perf != '1) ? r_perf + 32'd1 : r_perf;
    end
    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboarded bench for systolic_ctrl with behavioural operand buffers and PE grids.
module tb_systolic_ctrl;
    localparam int M0 = 5, N0 = 3, K0 = 4, M1 = 2, N1 = 2, K1 = 2, DW = 32;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int tests = 0, fails = 0, ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    logic start0 = 1'b0, x_en0, w_en0, clr0, busy0, done0;
    logic [1:0] x_addr0, w_addr0;
    logic [DW*M0-1:0] x_data0 = '0, arr_x0;
    logic [DW*K0-1:0] w_data0 = '0, arr_w0;
    logic [31:0] perf0;
    logic start1 = 1'b0, x_en1, w_en1, clr1, busy1, done1;
    logic [0:0] x_addr1, w_addr1;
    logic [DW*M1-1:0] x_data1 = '0, arr_x1;
    logic [DW*K1-1:0] w_data1 = '0, arr_w1;
    logic [31:0] perf1;

    systolic_ctrl u0 (.clk(clk), .rst(rst), .start(start0), .x_rd_en(x_en0), .x_rd_addr(x_addr0),
        .x_rd_data(x_data0), .w_rd_en(w_en0), .w_rd_addr(w_addr0), .w_rd_data(w_data0), .arr_x(arr_x0),
        .arr_w(arr_w0), .arr_clr(clr0), .busy(busy0), .done(done0), .perf_cycles(perf0));
    systolic_ctrl #(.M(M1), .N(N1), .K(K1)) u1 (.clk(clk), .rst(rst), .start(start1), .x_rd_en(x_en1),
        .x_rd_addr(x_addr1), .x_rd_data(x_data1), .w_rd_en(w_en1), .w_rd_addr(w_addr1), .w_rd_data(w_data1),
        .arr_x(arr_x1), .arr_w(arr_w1), .arr_clr(clr1), .busy(busy1), .done(done1), .perf_cycles(perf1));

    int X0[M0][N0], W0[N0][K0], X1[M1][N1], W1[N1][K1];
    int acc0[M0][K0], px0[M0][K0], pw0[M0][K0];
    int acc1[M1][K1], px1[M1][K1], pw1[M1][K1];
    int q0[$], q1[$], clr_q0[$], feed_q0[$];
    int done_cnt0 = 0, done_at0 = 0, xen_cnt0 = 0, done_cnt1 = 0, done_at1 = 0, first0 = -1, first1 = -1;
    logic prev_en0 = 1'b0;

    // One-cycle-latency operand buffers
    always @(posedge clk) begin
        if (x_en0) for (int i = 0; i < M0; i++) x_data0[DW*i +: DW] <= X0[i][x_addr0];
        if (w_en0) for (int j = 0; j < K0; j++) w_data0[DW*j +: DW] <= W0[w_addr0][j];
        if (x_en1) for (int i = 0; i < M1; i++) x_data1[DW*i +: DW] <= X1[i][x_addr1];
        if (w_en1) for (int j = 0; j < K1; j++) w_data1[DW*j +: DW] <= W1[w_addr1][j];
    end

    // Output-stationary PE grids: x moves right, w moves down, one register per hop
    always @(posedge clk) begin
        int a, b;
        for (int i = 0; i < M0; i++)
            for (int j = 0; j < K0; j++) begin
                if (j == 0) a = int'(arr_x0[DW*i +: DW]); else a = px0[i][j-1];
                if (i == 0) b = int'(arr_w0[DW*j +: DW]); else b = pw0[i-1][j];
                acc0[i][j] <= (rst || clr0) ? 0 : acc0[i][j] + a * b;
                px0[i][j] <= rst ? 0 : a;
                pw0[i][j] <= rst ? 0 : b;
            end
    end
    always @(posedge clk) begin
        int a, b;
        for (int i = 0; i < M1; i++)
            for (int j = 0; j < K1; j++) begin
                if (j == 0) a = int'(arr_x1[DW*i +: DW]); else a = px1[i][j-1];
                if (i == 0) b = int'(arr_w1[DW*j +: DW]); else b = pw1[i-1][j];
                acc1[i][j] <= (rst || clr1) ? 0 : acc1[i][j] + a * b;
                px1[i][j] <= rst ? 0 : a;
                pw1[i][j] <= rst ? 0 : b;
            end
    end

    always @(negedge clk) begin
        if (x_en0 || w_en0) begin
            tests++;
            if (w_en0 !== x_en0 || w_addr0 !== x_addr0) begin
                fails++;
                $display("FAIL rd_pair: w_en=%b w_addr=%0d, required x_en=%b x_addr=%0d", w_en0, w_addr0, x_en0, x_addr0);
            end
        end
        if (x_en0) xen_cnt0++;
        if (x_en0 && !prev_en0) feed_q0.push_back(ncyc);
        prev_en0 = x_en0;
        if (clr0) clr_q0.push_back(ncyc);
        if (done0) begin
            done_cnt0++;
            done_at0 = ncyc;
            for (int i = 0; i < M0; i++)
                for (int j = 0; j < K0; j++) begin
                    int e;
                    tests++;
                    if (q0.size() == 0) begin
                        fails++;
                        $display("FAIL y0_unexpected_done: got Y[%0d][%0d]=%0d, required no done", i, j, acc0[i][j]);
                    end else begin
                        e = q0.pop_front();
                        if (acc0[i][j] !== e) begin
                            fails++;
                            $display("FAIL y0[%0d][%0d]: got %0d, required %0d", i, j, acc0[i][j], e);
                        end
                    end
                end
        end
    end
    always @(negedge clk) begin
        if (first0 < 0 && arr_x1[DW-1:0] != 0) first0 = ncyc;
        if (first1 < 0 && arr_x1[2*DW-1:DW] != 0) first1 = ncyc;
        if (done1) begin
            done_cnt1++;
            done_at1 = ncyc;
            for (int i = 0; i < M1; i++)
                for (int j = 0; j < K1; j++) begin
                    int e;
                    tests++;
                    if (q1.size() == 0) begin
                        fails++;
                        $display("FAIL y1_unexpected_done: got Y[%0d][%0d]=%0d, required no done", i, j, acc1[i][j]);
                    end else begin
                        e = q1.pop_front();
                        if (acc1[i][j] !== e) begin
                            fails++;
                            $display("FAIL y1[%0d][%0d]: got %0d, required %0d", i, j, acc1[i][j], e);
                        end
                    end
                end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push_gold0;
        for (int i = 0; i < M0; i++)
            for (int j = 0; j < K0; j++) begin
                int s = 0;
                for (int k = 0; k < N0; k++) s += X0[i][k] * W0[k][j];
                q0.push_back(s);
            end
    endtask

    task automatic clear_mon0;
        done_cnt0 = 0;
        xen_cnt0 = 0;
        clr_q0.delete();
        feed_q0.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy0); end
        tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done0); end
        tests++; if (clr0 !== 1'b0) begin fails++; $display("FAIL reset_clr: got %b, required 0", clr0); end
        tests++; if (x_en0 !== 1'b0 || x_addr0 !== 2'd0) begin fails++; $display("FAIL reset_rd: got en=%b addr=%0d, required 0/0", x_en0, x_addr0); end
        tests++; if (arr_x0 !== '0 || arr_w0 !== '0) begin fails++; $display("FAIL reset_lanes: got x=%h w=%h, required 0", arr_x0, arr_w0); end
        tests++; if (perf0 !== 32'd0 || busy1 !== 1'b0) begin fails++; $display("FAIL reset_misc: got perf=%0d busy1=%b, required 0/0", perf0, busy1); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_matmul;
        int t0;
        for (int i = 0; i < M0; i++) for (int k = 0; k < N0; k++) X0[i][k] = i + k + 1;
        for (int k = 0; k < N0; k++) for (int j = 0; j < K0; j++) W0[k][j] = j - k + 2;
        push_gold0();
        clear_mon0();
        start0 = 1'b1;
        t0 = ncyc;
        tick();
        start0 = 1'b0;
        for (int n = 0; n < 40 && done_cnt0 == 0; n++) tick();
        repeat (2) tick();
        tests++; if (done_cnt0 != 1) begin fails++; $display("FAIL mm_done_count: got %0d, required 1", done_cnt0); end
        tests++; if (done_at0 - t0 != 14) begin fails++; $display("FAIL mm_done_cycle: got %0d, required 14", done_at0 - t0); end
        tests++; if (xen_cnt0 != N0) begin fails++; $display("FAIL mm_feed_beats: got %0d, required %0d", xen_cnt0, N0); end
        tests++; if ((clr_q0.size() > 0 ? clr_q0[0] - t0 : -1) != 1) begin fails++; $display("FAIL mm_clr_cycle: got %0d, required 1", clr_q0.size() > 0 ? clr_q0[0] - t0 : -1); end
        tests++; if ((feed_q0.size() > 0 ? feed_q0[0] - t0 : -1) != 2) begin fails++; $display("FAIL mm_feed_cycle: got %0d, required 2", feed_q0.size() > 0 ? feed_q0[0] - t0 : -1); end
        tests++; if (arr_x0 !== '0 || arr_w0 !== '0 || busy0 !== 1'b0) begin fails++; $display("FAIL mm_idle_after: got x=%h w=%h busy=%b, required 0", arr_x0, arr_w0, busy0); end
    endtask

    task automatic test_small;
        int t0;
        X1[0][0] = 1; X1[0][1] = 2; X1[1][0] = 3; X1[1][1] = 4;
        W1[0][0] = 1; W1[0][1] = 0; W1[1][0] = 0; W1[1][1] = 1;
        q1.push_back(1); q1.push_back(2); q1.push_back(3); q1.push_back(4);
        first0 = -1;
        first1 = -1;
        done_cnt1 = 0;
        start1 = 1'b1;
        t0 = ncyc;
        tick();
        start1 = 1'b0;
        for (int n = 0; n < 30 && done_cnt1 == 0; n++) tick();
        repeat (2) tick();
        tests++; if (done_cnt1 != 1) begin fails++; $display("FAIL small_done_count: got %0d, required 1", done_cnt1); end
        tests++; if (done_at1 - t0 != 8) begin fails++; $display("FAIL small_done_cycle: got %0d, required 8", done_at1 - t0); end
        tests++; if (first0 - t0 != 3) begin fails++; $display("FAIL small_lane0_first: got %0d, required 3", first0 - t0); end
        tests++; if (first1 - first0 != 1) begin fails++; $display("FAIL small_lane_lag: got %0d, required 1", first1 - first0); end
    endtask

    task automatic test_ignore_start;
        push_gold0();
        clear_mon0();
        start0 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            start0 = (n == 3 || n == 7);
        end
        tests++; if (done_cnt0 != 1) begin fails++; $display("FAIL ign_done_count: got %0d, required 1", done_cnt0); end
        tests++; if (xen_cnt0 != N0) begin fails++; $display("FAIL ign_feed_beats: got %0d, required %0d", xen_cnt0, N0); end
        tests++; if (clr_q0.size() != 1 || q0.size() != 0) begin fails++; $display("FAIL ign_runs: got clr=%0d pending=%0d, required 1/0", clr_q0.size(), q0.size()); end
    endtask

    task automatic test_rst_mid;
        int t0;
        push_gold0();
        clear_mon0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (busy0 !== 1'b0 || clr0 !== 1'b0 || x_en0 !== 1'b0) begin fails++; $display("FAIL rst_ctrl: got busy=%b clr=%b en=%b, required 0", busy0, clr0, x_en0); end
        tests++; if (arr_x0 !== '0 || arr_w0 !== '0) begin fails++; $display("FAIL rst_lanes: got x=%h w=%h, required 0", arr_x0, arr_w0); end
        repeat (20) tick();
        tests++; if (done_cnt0 != 0) begin fails++; $display("FAIL rst_no_done: got %0d, required 0", done_cnt0); end
        q0.delete();
        push_gold0();
        start0 = 1'b1;
        t0 = ncyc;
        tick();
        start0 = 1'b0;
        for (int n = 0; n < 40 && done_cnt0 == 0; n++) tick();
        tests++; if (done_cnt0 != 1 || done_at0 - t0 != 14) begin fails++; $display("FAIL rst_rerun: got count=%0d cycle=%0d, required 1/14", done_cnt0, done_at0 - t0); end
        tick();
    endtask

    task automatic test_back_to_back;
        int t0;
        repeat (3) push_gold0();
        clear_mon0();
        start0 = 1'b1;
        t0 = ncyc;
        for (int n = 1; n < 80 && done_cnt0 < 3; n++) begin
            tick();
            if (n == 31) start0 = 1'b0;
        end
        start0 = 1'b0;
        repeat (20) tick();
        tests++; if (done_cnt0 != 3 || clr_q0.size() != 3) begin fails++; $display("FAIL b2b_runs: got done=%0d clr=%0d, required 3/3", done_cnt0, clr_q0.size()); end
        for (int r = 0; r < 3; r++) begin
            int c, f;
            c = (r < clr_q0.size()) ? clr_q0[r] - t0 : -1;
            f = (r < feed_q0.size() && r < clr_q0.size()) ? feed_q0[r] - clr_q0[r] : -1;
            tests++; if (c != 1 + 15 * r) begin fails++; $display("FAIL b2b_clr_cycle[%0d]: got %0d, required %0d", r, c, 1 + 15 * r); end
            tests++; if (f != 1) begin fails++; $display("FAIL b2b_clr_to_feed[%0d]: got %0d, required 1", r, f); end
        end
    endtask

    task automatic test_perf;
        int exp_perf;
`ifdef SYSTOLIC_CTRL_PERF_EN
        exp_perf = 28;
`else
        exp_perf = 0;
`endif
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_mon0();
        for (int r = 0; r < 2; r++) begin
            push_gold0();
            start0 = 1'b1;
            tick();
            start0 = 1'b0;
            for (int n = 0; n < 40 && done_cnt0 == r; n++) tick();
            tick();
        end
        repeat (3) tick();
        tests++; if (done_cnt0 != 2) begin fails++; $display("FAIL perf_runs: got %0d, required 2", done_cnt0); end
        tests++; if (perf0 !== 32'(exp_perf)) begin fails++; $display("FAIL perf_cycles: got %0d, required %0d", perf0, exp_perf); end
        tests++; if (perf1 !== 32'd0) begin fails++; $display("FAIL perf_idle_inst: got %0d, required 0", perf1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_matmul();
        test_small();
        test_ignore_start();
        test_rst_mid();
        test_back_to_back();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
